btn_conditioner: RTL
====================

Name: btn_conditioner

Overview:
- Conditions the raw board pushbuttons (start, minute, five-second, reset, mode) into clean control for the downstream timer and clock stages.
- Per button: 2-FF synchroniser, then a debounce filter producing a clean level.
- From that level it generates one-cycle press pulses with optional hold-to-auto-repeat, one-cycle release pulses, and a press-toggled level (for start/pause).
- Sits between the top-level pins and the timer; runs entirely on clk100MHz.

Parameters:
- NUM_BTN, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); must be >=1.
- HOLD_CYCLES, 50000000, cycles from accepted press to first auto-repeat pulse (500 ms).
- REPEAT_CYCLES, 10000000, cycles between subsequent auto-repeat pulses (100 ms).
- REPEAT_EN, {NUM_BTN{1'b0}}, per-channel mask; bit=1 enables auto-repeat on that channel.

Ports:
- clk100MHz  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_raw  input  NUM_BTN  asynchronous raw button pins, 1 = pressed.
- btn_level  output  NUM_BTN  debounced level.
- btn_press  output  NUM_BTN  one-cycle pulse on accepted press and on each auto-repeat.
- btn_release  output  NUM_BTN  one-cycle pulse on accepted release.
- btn_toggle  output  NUM_BTN  flips on each accepted press (not on repeats).

Behaviour:
- One clock (clk100MHz); reset is synchronous and active-high (rst). All outputs are registered.
- Reset: synchroniser FFs, debounce/hold counters, btn_level, btn_press, btn_release and btn_toggle all clear to 0; channel FSM goes to IDLE. A mid-operation reset aborts any debounce/hold in progress. No pulse is emitted during the reset cycle or in the cycle after it.
- Synchroniser: 2 FFs; sync = raw delayed 2 cycles.
- Debounce counter (width $clog2(DEBOUNCE_CYCLES+1)):
  - Clears whenever sync == btn_level; increments while sync != btn_level.
  - On the edge where count == DEBOUNCE_CYCLES-1 and sync != btn_level, btn_level takes sync and the count clears.
  - Raw-to-level latency = 2 + DEBOUNCE_CYCLES cycles. Any bounce back restarts the count.
- Channel FSM states:
  - IDLE: level 0.
  - HELD: level 1, hold counter running.
  - REPEAT: level 1, repeat counter running.
- FSM transitions:
  - IDLE -> HELD on level rise: btn_press=1 and btn_toggle flips in the same cycle btn_level first reads 1; hold counter clears.
  - HELD: the hold counter increments each cycle. When it reaches HOLD_CYCLES-1 and REPEAT_EN[i]=1, btn_press pulses on the next cycle (HOLD_CYCLES after the initial press) and the FSM moves to REPEAT with the repeat counter cleared. If REPEAT_EN[i]=0, the FSM stays in HELD and the counter saturates.
  - REPEAT: btn_press pulses every REPEAT_CYCLES cycles.
  - HELD/REPEAT -> IDLE on level fall: btn_release=1 in the cycle btn_level first reads 0; counters clear.
- Priority: a level fall in the same cycle a repeat is due suppresses the repeat pulse. Press and release never coincide on one channel.
- Raw held high through reset: after rst deasserts, the press is accepted 2 + DEBOUNCE_CYCLES cycles later.
- Channels are fully independent; simultaneous events on different channels all fire in the same cycle.

Decomposition:
- Shared package watch_pkg holds CLK_HZ=100000000 and the default debounce/hold/repeat cycle constants, so the timer and other stages share timing.
- One sub-module, btn_channel: synchroniser, debounce, FSM and counters for a single bit. The top instantiates NUM_BTN copies via generate, passing REPEAT_EN[i].

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5; cycle 0 = raw edge.)
- Clean press: raw[0] 0->1 at cycle 0 and held -> btn_level[0]=1 from cycle 6; btn_press[0]=1 only at cycle 6; btn_toggle[0]=1.
- Bounce: raw[1] =1,0,1 on cycles 0,1,2 then stable 1 -> exactly one btn_press[1], at cycle 8.
- Auto-repeat, REPEAT_EN=4'b0001:
  - raw[0] high for cycles 0-39 -> btn_press[0] at 6, 26, 31, 36, 41.
  - Level falls at 46: btn_release[0] at 46 and the repeat due at 46 is suppressed.
  - Same stimulus with REPEAT_EN=0 -> only the pulse at 6.
- Glitch reject: raw[2] high for cycles 0-2 only -> btn_level[2], btn_press[2] and btn_release[2] stay 0 throughout.
- Reset mid-hold: raw[0] held high, rst=1 at cycle 15 for one cycle -> all outputs 0 from cycle 16, btn_toggle[0] cleared; re-press accepted at cycle 22 (2+4 cycles after reset release) with one btn_press.
- Simultaneous: raw[3:0]=4'b1111 at cycle 0 -> btn_press=4'b1111 in cycle 6 only; btn_toggle=4'b1111.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared timing constants and channel state type for the watch datapath.
package watch_pkg;

  localparam int unsigned CLK_HZ                  = 100_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;   // 10 ms
  localparam int unsigned HOLD_CYCLES_DEFAULT     = 50_000_000;  // 500 ms
  localparam int unsigned REPEAT_CYCLES_DEFAULT   = 10_000_000;  // 100 ms

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_e;

  // Counter width able to hold values 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-FF synchroniser, debounce filter, press/repeat/release FSM.
module btn_channel
  import watch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEFAULT,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT,
  parameter logic        REPEAT_EN       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic toggle_o
);

  localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int unsigned REP_W  = cnt_width(REPEAT_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  logic              sync1_q, sync2_q;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              level_q, level_d;
  logic              accept;
  logic              rise, fall;

  btn_state_e        state_q;
  logic [HOLD_W-1:0] hold_q;
  logic [REP_W-1:0]  rep_q;
  logic              press_q, release_q, toggle_q;

  // Two-stage synchroniser for the asynchronous pin.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive mismatch cycles, accept on the last one.
  // The FSM keys off 'accept' rather than level_q so its pulses land in the
  // same cycle the new level first becomes visible.
  assign accept = (sync2_q != level_q) && (db_cnt_q == DB_LAST);
  assign rise   = accept &  sync2_q;
  assign fall   = accept & ~sync2_q;

  // Next-state for debounce counter and accepted level.
  always_comb begin
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    if (sync2_q == level_q) begin
      db_cnt_d = '0;
    end else if (accept) begin
      db_cnt_d = '0;
      level_d  = sync2_q;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      db_cnt_q <= '0;
      level_q  <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
    end
  end

  // Channel FSM with registered press/release/toggle outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      rep_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            press_q  <= 1'b1;
            toggle_q <= ~toggle_q;
            hold_q   <= '0;
            state_q  <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (fall) begin
            release_q <= 1'b1;
            hold_q    <= '0;
            state_q   <= ST_IDLE;
          end else if (hold_q == HOLD_LAST) begin
            // Without repeat enabled the counter simply saturates here.
            if (REPEAT_EN) begin
              press_q <= 1'b1;
              rep_q   <= '0;
              state_q <= ST_REPEAT;
            end
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          // A fall wins over a repeat due in the same cycle.
          if (fall) begin
            release_q <= 1'b1;
            hold_q    <= '0;
            rep_q     <= '0;
            state_q   <= ST_IDLE;
          end else if (rep_q == REP_LAST) begin
            press_q <= 1'b1;
            rep_q   <= '0;
          end else begin
            rep_q <= rep_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          hold_q  <= '0;
          rep_q   <= '0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign toggle_o  = toggle_q;

endmodule

// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: NUM_BTN independent synchronise/debounce/FSM channels.
module btn_conditioner
  import watch_pkg::*;
#(
  parameter int unsigned         NUM_BTN         = 4,
  parameter int unsigned         DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned         HOLD_CYCLES     = HOLD_CYCLES_DEFAULT,
  parameter int unsigned         REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT,
  parameter logic [NUM_BTN-1:0]  REPEAT_EN       = '0
) (
  input  logic               clk100MHz,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_toggle
);

  // One fully independent channel per button.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (REPEAT_EN[i])
    ) u_ch (
      .clk_i     (clk100MHz),
      .rst_i     (rst),
      .raw_i     (btn_raw[i]),
      .level_o   (btn_level[i]),
      .press_o   (btn_press[i]),
      .release_o (btn_release[i]),
      .toggle_o  (btn_toggle[i])
    );
  end

endmodule
